// File: rtl/ldpc_pkg.sv
// Shared LDPC message types: default message format, check-node state enum and
// sign/magnitude helpers for two's-complement LLRs.
package ldpc_pkg;

    localparam int MSG_INT  = 8;
    localparam int MSG_FRAC = 8;
    localparam int MSG_W    = MSG_INT + MSG_FRAC;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cn_state_e;

    // Helpers take 32-bit sign-extended values so any message width up to 32 can share them.
    function automatic logic [31:0] abs_sat(input logic [31:0] v, input int w);
        logic [31:0] lim;
        logic [31:0] m;
        lim = (32'd1 << (w - 1)) - 32'd1;
        m   = v[31] ? (~v + 32'd1) : v;
        return (m > lim) ? lim : m;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic sgn);
        return sgn ? (~mag + 32'd1) : mag;
    endfunction

endpackage

// File: rtl/cn_min_track.sv
// Running min1/min2/argmin/sign-parity tracker for one check node; the clear
// input restores the start-of-frame values. Next-state values are exported.
module cn_min_track
#(
    parameter int W  = 16,
    parameter int IW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          upd_i,
    input  logic [W-2:0]  mag_i,
    input  logic [IW-1:0] pos_i,
    input  logic          sgn_i,
    output logic [W-2:0]  min1_o,
    output logic [W-2:0]  min2_o,
    output logic [IW-1:0] idx_o,
    output logic          parity_o,
    output logic [W-2:0]  min1_nxt_o,
    output logic [W-2:0]  min2_nxt_o,
    output logic [IW-1:0] idx_nxt_o,
    output logic          parity_nxt_o
);

    logic [W-2:0]  min1_q, min1_d;
    logic [W-2:0]  min2_q, min2_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          parity_q, parity_d;

    // Strict compares keep the earliest index on ties.
    always_comb begin
        min1_d   = min1_q;
        min2_d   = min2_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        if (clear_i) begin
            min1_d   = {(W-1){1'b1}};
            min2_d   = {(W-1){1'b1}};
            idx_d    = {IW{1'b0}};
            parity_d = 1'b0;
        end else if (upd_i) begin
            parity_d = parity_q ^ sgn_i;
            if (mag_i < min1_q) begin
                min2_d = min1_q;
                min1_d = mag_i;
                idx_d  = pos_i;
            end else if (mag_i < min2_q) begin
                min2_d = mag_i;
            end else begin
                min2_d = min2_q;
            end
        end else begin
            parity_d = parity_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min1_q   <= {(W-1){1'b1}};
            min2_q   <= {(W-1){1'b1}};
            idx_q    <= {IW{1'b0}};
            parity_q <= 1'b0;
        end else begin
            min1_q   <= min1_d;
            min2_q   <= min2_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
        end
    end

    assign min1_o       = min1_q;
    assign min2_o       = min2_q;
    assign idx_o        = idx_q;
    assign parity_o     = parity_q;
    assign min1_nxt_o   = min1_d;
    assign min2_nxt_o   = min2_d;
    assign idx_nxt_o    = idx_d;
    assign parity_nxt_o = parity_d;

endmodule

// File: rtl/cn_minsum_serial.sv
// Serial min-sum check-node processor: DC messages in, DC messages out per frame.
// Build option CN_OFFSET_EN selects offset min-sum (output magnitude reduced by OFFSET).
module cn_minsum_serial
    import ldpc_pkg::*;
#(
    parameter int INT  = MSG_INT,
    parameter int FRAC = MSG_FRAC,
    parameter int DC   = 6,
    parameter logic [INT+FRAC-2:0] OFFSET = {(INT+FRAC-1){1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INT+FRAC-1:0] in_msg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INT+FRAC-1:0] out_msg,
    output logic                out_last
);

    localparam int W  = INT + FRAC;
    localparam int CW = $clog2(DC);

`ifdef CN_OFFSET_EN
    localparam logic [W-2:0] OFS = OFFSET;
`else
    // Plain min-sum: the offset collapses to zero.
    localparam logic [W-2:0] OFS = OFFSET & {(W-1){1'b0}};
`endif

    cn_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d, cnt_inc_s;
    logic [DC-1:0] sign_q, sign_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [W-1:0]  out_msg_q, out_msg_d;
    logic          accept_s, emit_s, cnt_end_s, clear_s;
    logic [W-2:0]  mag_in_s, min1_s, min2_s, min1_nxt_s, min2_nxt_s;
    logic [CW-1:0] idx_s, idx_nxt_s;
    logic          par_s, par_nxt_s;

    function automatic logic [W-1:0] c2v(input logic [W-2:0] m1, input logic [W-2:0] m2,
                                         input logic [CW-1:0] idx, input logic [CW-1:0] j,
                                         input logic par, input logic sj);
        logic [W-2:0] mag;
        mag = (j == idx) ? m2 : m1;
        mag = (mag > OFS) ? (mag - OFS) : {(W-1){1'b0}};
        return W'(apply_sign(32'(mag), par ^ sj));
    endfunction

    assign accept_s  = in_valid && in_ready;
    assign emit_s    = out_valid_q && out_ready;
    assign cnt_end_s = (count_q == CW'(DC - 1));
    assign cnt_inc_s = count_q + CW'(1);
    assign clear_s   = (state_q == EMIT) && emit_s && cnt_end_s;
    assign mag_in_s  = (W-1)'(abs_sat(32'(signed'(in_msg)), W));

    cn_min_track #(.W(W), .IW(CW)) u_track (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear_s),
        .upd_i        (accept_s),
        .mag_i        (mag_in_s),
        .pos_i        (count_q),
        .sgn_i        (in_msg[W-1]),
        .min1_o       (min1_s),
        .min2_o       (min2_s),
        .idx_o        (idx_s),
        .parity_o     (par_s),
        .min1_nxt_o   (min1_nxt_s),
        .min2_nxt_o   (min2_nxt_s),
        .idx_nxt_o    (idx_nxt_s),
        .parity_nxt_o (par_nxt_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a frame is collected, then fully emitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: state_d = (accept_s && cnt_end_s) ? EMIT : COLLECT;
            EMIT:    state_d = (emit_s && cnt_end_s) ? COLLECT : EMIT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM output: accept input only while collecting and out of reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && state_q == COLLECT) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Counter, sign store and output register next-state.
    always_comb begin
        count_d     = count_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_msg_d   = out_msg_q;
        out_last_d  = out_last_q;
        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    sign_d[count_q] = in_msg[W-1];
                    count_d         = cnt_end_s ? {CW{1'b0}} : cnt_inc_s;
                end else begin
                    count_d = count_q;
                end
                // First output is built from the statistics that include the last input.
                if (accept_s && cnt_end_s) begin
                    out_valid_d = 1'b1;
                    out_msg_d   = c2v(min1_nxt_s, min2_nxt_s, idx_nxt_s, {CW{1'b0}}, par_nxt_s, sign_d[0]);
                    out_last_d  = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            EMIT: begin
                if (emit_s && cnt_end_s) begin
                    count_d     = {CW{1'b0}};
                    sign_d      = {DC{1'b0}};
                    out_valid_d = 1'b0;
                    out_msg_d   = {W{1'b0}};
                    out_last_d  = 1'b0;
                end else if (emit_s) begin
                    count_d    = cnt_inc_s;
                    out_msg_d  = c2v(min1_s, min2_s, idx_s, cnt_inc_s, par_s, sign_q[cnt_inc_s]);
                    out_last_d = (cnt_inc_s == CW'(DC - 1));
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                count_d     = {CW{1'b0}};
                sign_d      = {DC{1'b0}};
                out_valid_d = 1'b0;
                out_msg_d   = {W{1'b0}};
                out_last_d  = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= {CW{1'b0}};
            sign_q      <= {DC{1'b0}};
            out_valid_q <= 1'b0;
            out_msg_q   <= {W{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_last  = out_last_q;

endmodule
